gate_test_sequencer: RTL and testbench

Self-checking stimulus controller for a single-input, single-output logic gate under test (the inverter cell and its successors). Drives the gate input through a parameterised bit pattern, waits a programmable settle time per vector, samples the gate output, compares it against the expected inverted value and accumulates an error count. It sits between a top-level test/bring-up harness, which issues Start and reads Pass/ErrCount, and the gate instance, whose Xin/Yout it owns.

---
 rtl/gate_test_pkg.sv | 21 ++
 rtl/gate_test_sequencer_settle_timer.sv | 37 +++
 rtl/gate_test_sequencer.sv | 115 +++++++++++
 tb/tb_gate_test_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencers: FSM encodings and default stimulus.
// Pure declarations; no latency or flow-control behaviour.
package gate_test_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_DRIVE_ENC  = 3'd1;
  localparam logic [2:0] ST_SETTLE_ENC = 3'd2;
  localparam logic [2:0] ST_SAMPLE_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_DRIVE  = ST_DRIVE_ENC,
    ST_SETTLE = ST_SETTLE_ENC,
    ST_SAMPLE = ST_SAMPLE_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'b1010_0101;

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Settle-time down-counter: load, decrement, expired when the count reaches its last cycle.
// Expired is combinational from the count register; no backpressure.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry fires on the edge that would take the count from 1 to 0.
  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives a single-input gate through PATTERN, samples its output after a settle time, counts mismatches.
// One run takes NUM_VECTORS*(SETTLE_CYCLES+2) cycles; Start outside IDLE is ignored.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int                     NUM_VECTORS   = 8,
  parameter logic [NUM_VECTORS-1:0] PATTERN       = NUM_VECTORS'(DEFAULT_PATTERN),
  parameter int                     SETTLE_CYCLES = 2,
  parameter int                     ERR_W         = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             GateIn,
  input  logic             GateOut,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrCount
);

  localparam int VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  state_t           state_q, state_d;
  logic             gate_in_q, gate_in_d;
  logic [VW-1:0]    vec_idx_q, vec_idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_expired;

  settle_timer #(
    .W (SW)
  ) u_settle_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (SW'(SETTLE_CYCLES)),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    gate_in_d = gate_in_q;
    vec_idx_d = vec_idx_q;
    err_d     = err_q;
    pass_d    = pass_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          err_d     = '0;
          pass_d    = 1'b0;
          vec_idx_d = '0;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        gate_in_d = PATTERN[vec_idx_q];
        tmr_load  = 1'b1;
        state_d   = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Saturate rather than wrap so a badly broken gate never reads as passing.
        if ((GateOut != ~gate_in_q) && (err_q != '1)) begin
          err_d = err_q + 1'b1;
        end
        if (vec_idx_q == VW'(NUM_VECTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          vec_idx_d = vec_idx_q + 1'b1;
          state_d   = ST_DRIVE;
        end
      end
      ST_DONE: begin
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      gate_in_q <= 1'b0;
      vec_idx_q <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_in_q <= gate_in_d;
      vec_idx_q <= vec_idx_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
    end
  end

  assign GateIn   = gate_in_q;
  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_DONE);
  assign Pass     = pass_q;
  assign ErrCount = err_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench: three sequencer instances (default, zero settle, 300 vectors) with selectable gate models.
module tb_gate_test_sequencer;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic start = 1'b0;
  int   sel = 0;
  int   gm = 0;

  int checks = 0;
  int errors = 0;

  logic       d_start, d_gin, d_gout, d_busy, d_done, d_pass;
  logic [7:0] d_err;
  logic       z_start, z_gin, z_gout, z_busy, z_done, z_pass;
  logic [7:0] z_err;
  logic       b_start, b_gin, b_gout, b_busy, b_done, b_pass;
  logic [7:0] b_err;
  logic       inv_q;

  logic       o_gin, o_busy, o_done, o_pass;
  logic [7:0] o_err;
  logic [7:0] gin_seq;
  logic       pass_e1;
  logic [7:0] err_e1;

  always #5 Clk = ~Clk;

  gate_test_sequencer u_def (
    .Clk(Clk), .Rst(Rst), .Start(d_start), .GateIn(d_gin), .GateOut(d_gout),
    .Busy(d_busy), .Done(d_done), .Pass(d_pass), .ErrCount(d_err)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(0)) u_s0 (
    .Clk(Clk), .Rst(Rst), .Start(z_start), .GateIn(z_gin), .GateOut(z_gout),
    .Busy(z_busy), .Done(z_done), .Pass(z_pass), .ErrCount(z_err)
  );

  gate_test_sequencer #(.NUM_VECTORS(300), .PATTERN(300'h0)) u_big (
    .Clk(Clk), .Rst(Rst), .Start(b_start), .GateIn(b_gin), .GateOut(b_gout),
    .Busy(b_busy), .Done(b_done), .Pass(b_pass), .ErrCount(b_err)
  );

  // Gate models: 0 = registered inverter, 1 = stuck-at-0, 2 = combinational buffer.
  always @(posedge Clk) inv_q <= ~d_gin;
  assign d_gout = (gm == 0) ? inv_q : (gm == 1) ? 1'b0 : d_gin;
  assign z_gout = z_gin;
  assign b_gout = b_gin;

  assign d_start = start && (sel == 0);
  assign z_start = start && (sel == 1);
  assign b_start = start && (sel == 2);

  assign o_gin  = (sel == 0) ? d_gin  : (sel == 1) ? z_gin  : b_gin;
  assign o_busy = (sel == 0) ? d_busy : (sel == 1) ? z_busy : b_busy;
  assign o_done = (sel == 0) ? d_done : (sel == 1) ? z_done : b_done;
  assign o_pass = (sel == 0) ? d_pass : (sel == 1) ? z_pass : b_pass;
  assign o_err  = (sel == 0) ? d_err  : (sel == 1) ? z_err  : b_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses Start into edge 0, then watches edges 1..n_edges; optional Start re-pulses at edges pa/pb.
  task automatic run_dut(input int s, input int n_edges, input int pa, input int pb,
                         output int done_edge, output int ndone, output int busy_gap);
    sel = s;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    done_edge = -1;
    ndone     = 0;
    busy_gap  = 0;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge Clk);
      #1;
      if (o_done) begin
        ndone++;
        if (done_edge < 0) done_edge = e;
      end
      if ((done_edge < 0) && !o_busy) busy_gap++;
      if ((e % 4 == 1) && (e <= 29)) gin_seq[(e - 1) / 4] = o_gin;
      if (e == 1) begin
        pass_e1 = o_pass;
        err_e1  = o_err;
      end
      start = ((e + 1) == pa) || ((e + 1) == pb);
    end
    start = 1'b0;
  endtask

  initial begin
    int de, nd, bg;

    #2;
    chk("rst_gatein", d_gin, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_done", d_done, 0);
    chk("rst_pass", d_pass, 0);
    chk("rst_errcount", d_err, 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // Inverter connected, defaults.
    gm = 0;
    run_dut(0, 33, 0, 0, de, nd, bg);
    chk("inv_done_edge", de, 32);
    chk("inv_done_count", nd, 1);
    chk("inv_busy_gap", bg, 0);
    chk("inv_gatein_seq", gin_seq, 8'b1010_0101);
    chk("inv_pass", o_pass, 1);
    chk("inv_errcount", o_err, 0);
    chk("inv_idle_busy", o_busy, 0);

    // Stuck-at-0 output.
    gm = 1;
    run_dut(0, 33, 0, 0, de, nd, bg);
    chk("sa0_pass_cleared", pass_e1, 0);
    chk("sa0_err_cleared", err_e1, 0);
    chk("sa0_done_edge", de, 32);
    chk("sa0_errcount", o_err, 4);
    chk("sa0_pass", o_pass, 0);

    // Buffer model with zero settle time.
    run_dut(1, 17, 0, 0, de, nd, bg);
    chk("buf0_done_edge", de, 16);
    chk("buf0_errcount", o_err, 8);
    chk("buf0_pass", o_pass, 0);

    // Start re-pulsed mid-run must be ignored.
    gm = 0;
    run_dut(0, 33, 5, 20, de, nd, bg);
    chk("repulse_done_edge", de, 32);
    chk("repulse_done_count", nd, 1);
    chk("repulse_busy_gap", bg, 0);
    chk("repulse_pass", o_pass, 1);

    // Reset during vector 3 with a stuck-at-0 gate, then a clean rerun.
    gm = 1;
    sel = 0;
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge Clk);
      #1;
    end
    chk("prerst_errcount", d_err, 1);
    chk("prerst_gatein", d_gin, 1);
    Rst = 1'b1;
    #1;
    chk("midrst_gatein", d_gin, 0);
    chk("midrst_busy", d_busy, 0);
    chk("midrst_done", d_done, 0);
    chk("midrst_pass", d_pass, 0);
    chk("midrst_errcount", d_err, 0);
    nd = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge Clk);
      #1;
      nd += int'(d_done);
    end
    chk("midrst_no_done", nd, 0);
    @(negedge Clk);
    Rst = 1'b0;
    gm = 0;
    run_dut(0, 33, 0, 0, de, nd, bg);
    chk("rerun_done_edge", de, 32);
    chk("rerun_done_count", nd, 1);
    chk("rerun_pass", o_pass, 1);
    chk("rerun_errcount", o_err, 0);

    // 300 vectors against a buffer: the error count saturates.
    run_dut(2, 1201, 0, 0, de, nd, bg);
    chk("big_done_edge", de, 1200);
    chk("big_errcount_sat", o_err, 255);
    chk("big_pass", o_pass, 0);
    chk("big_done_count", nd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
